// File: rtl/core_pkg.sv
// Shared core types: arbiter FSM states and port-owner encoding.
package core_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_WAIT_RESP
   } arb_state_e;

   typedef enum logic {
      OWNER_IF,
      OWNER_LSU
   } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, LSU and memory-side req/gnt/rvalid signals around the arbiter.
// slave = arbiter view (serves the requesters, drives memory); master = core + memory view.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_WIDTH-1:0] if_rdata;

   logic                  lsu_req;
   logic                  lsu_we;
   logic [BE_WIDTH-1:0]   lsu_be;
   logic [ADDR_WIDTH-1:0] lsu_addr;
   logic [DATA_WIDTH-1:0] lsu_wdata;
   logic                  lsu_gnt;
   logic                  lsu_rvalid;
   logic [DATA_WIDTH-1:0] lsu_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [BE_WIDTH-1:0]   mem_be;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output lsu_gnt, lsu_rvalid, lsu_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  lsu_gnt, lsu_rvalid, lsu_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction outstanding.
// gnt can come in the request cycle, rvalid passes straight through; losers wait in IDLE, no buffering.
module mem_arbiter
   import core_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int LSU_PRIORITY = 1
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          busy_o
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   arb_state_e            state_q;
   arb_owner_e            owner_q;
   arb_owner_e            rr_last_q;
   logic                  hold_we_q;
   logic [BE_WIDTH-1:0]   hold_be_q;
   logic [ADDR_WIDTH-1:0] hold_addr_q;
   logic [DATA_WIDTH-1:0] hold_wdata_q;

   logic                  win_vld;
   arb_owner_e            win;
   logic                  win_we;
   logic [BE_WIDTH-1:0]   win_be;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   logic                  issue;
   logic                  gnt_ok;
   logic                  rsp_ok;
   arb_owner_e            gnt_owner;

   // Winner select; fetch is read-only, so its write fields are fixed.
   always_comb begin
      win_vld = bus.if_req | bus.lsu_req;
      win     = OWNER_IF;
      if (bus.if_req && bus.lsu_req) begin
         win = (LSU_PRIORITY != 0 || rr_last_q == OWNER_IF) ? OWNER_LSU : OWNER_IF;
      end else if (bus.lsu_req) begin
         win = OWNER_LSU;
      end
      if (win == OWNER_LSU) begin
         win_we    = bus.lsu_we;
         win_be    = bus.lsu_be;
         win_addr  = bus.lsu_addr;
         win_wdata = bus.lsu_wdata;
      end else begin
         win_we    = 1'b0;
         win_be    = '1;
         win_addr  = bus.if_addr;
         win_wdata = '0;
      end
   end

   always_comb begin
      issue     = !rst && ((state_q == ARB_IDLE && win_vld) || state_q == ARB_REQ);
      gnt_ok    = issue && bus.mem_gnt;
      rsp_ok    = !rst && state_q == ARB_WAIT_RESP && bus.mem_rvalid;
      gnt_owner = (state_q == ARB_REQ) ? owner_q : win;

      bus.mem_req   = issue;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (issue && state_q == ARB_REQ) begin
         bus.mem_we    = hold_we_q;
         bus.mem_be    = hold_be_q;
         bus.mem_addr  = hold_addr_q;
         bus.mem_wdata = hold_wdata_q;
      end else if (issue) begin
         bus.mem_we    = win_we;
         bus.mem_be    = win_be;
         bus.mem_addr  = win_addr;
         bus.mem_wdata = win_wdata;
      end

      bus.if_gnt     = gnt_ok && gnt_owner == OWNER_IF;
      bus.lsu_gnt    = gnt_ok && gnt_owner == OWNER_LSU;
      bus.if_rvalid  = rsp_ok && owner_q == OWNER_IF;
      bus.lsu_rvalid = rsp_ok && owner_q == OWNER_LSU;
      bus.if_rdata   = bus.if_rvalid  ? bus.mem_rdata : '0;
      bus.lsu_rdata  = bus.lsu_rvalid ? bus.mem_rdata : '0;

      busy_o = !rst && state_q != ARB_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWNER_IF;
         rr_last_q    <= OWNER_LSU;
         hold_we_q    <= 1'b0;
         hold_be_q    <= '0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (win_vld) begin
                  owner_q      <= win;
                  hold_we_q    <= win_we;
                  hold_be_q    <= win_be;
                  hold_addr_q  <= win_addr;
                  hold_wdata_q <= win_wdata;
                  state_q      <= bus.mem_gnt ? ARB_WAIT_RESP : ARB_REQ;
               end
            end
            ARB_REQ: begin
               if (bus.mem_gnt) state_q <= ARB_WAIT_RESP;
            end
            ARB_WAIT_RESP: begin
               if (bus.mem_rvalid) begin
                  rr_last_q <= owner_q;
                  state_q   <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: priority arbiter (p_*) for most scenarios, round-robin arbiter (r_*) for fairness.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic p_busy, r_busy;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) p_bus ();
   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) r_bus ();

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LSU_PRIORITY(1)) u_prio (
      .clk(clk), .rst(rst), .bus(p_bus), .busy_o(p_busy));
   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LSU_PRIORITY(0)) u_rr (
      .clk(clk), .rst(rst), .bus(r_bus), .busy_o(r_busy));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic p_idle_inputs();
      p_bus.if_req = 0; p_bus.if_addr = '0;
      p_bus.lsu_req = 0; p_bus.lsu_we = 0; p_bus.lsu_be = '0;
      p_bus.lsu_addr = '0; p_bus.lsu_wdata = '0;
      p_bus.mem_gnt = 0; p_bus.mem_rvalid = 0; p_bus.mem_rdata = '0;
   endtask

   task automatic p_outputs_zero(input string tag);
      check({tag, "_mem_req"},    p_bus.mem_req, 0);
      check({tag, "_mem_addr"},   p_bus.mem_addr, 0);
      check({tag, "_if_gnt"},     p_bus.if_gnt, 0);
      check({tag, "_lsu_gnt"},    p_bus.lsu_gnt, 0);
      check({tag, "_if_rvalid"},  p_bus.if_rvalid, 0);
      check({tag, "_lsu_rvalid"}, p_bus.lsu_rvalid, 0);
      check({tag, "_if_rdata"},   p_bus.if_rdata, 0);
      check({tag, "_busy"},       p_busy, 0);
   endtask

   initial begin
      p_idle_inputs();
      r_bus.if_req = 0; r_bus.if_addr = '0;
      r_bus.lsu_req = 0; r_bus.lsu_we = 0; r_bus.lsu_be = '0;
      r_bus.lsu_addr = '0; r_bus.lsu_wdata = '0;
      r_bus.mem_gnt = 0; r_bus.mem_rvalid = 0; r_bus.mem_rdata = '0;

      // Reset with activity on every input: outputs must stay quiet.
      tick();
      p_bus.if_req = 1; p_bus.if_addr = 32'h55; p_bus.mem_gnt = 1;
      p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'hFFFF_0000;
      settle();
      p_outputs_zero("rst");
      tick();
      p_idle_inputs();
      rst = 0;
      tick();

      // 1: single fetch, grant same cycle, response next cycle.
      p_bus.if_req = 1; p_bus.if_addr = 32'h100; p_bus.mem_gnt = 1;
      settle();
      check("t1_mem_req",  p_bus.mem_req, 1);
      check("t1_mem_addr", p_bus.mem_addr, 32'h100);
      check("t1_mem_we",   p_bus.mem_we, 0);
      check("t1_mem_be",   p_bus.mem_be, 4'hF);
      check("t1_if_gnt",   p_bus.if_gnt, 1);
      check("t1_lsu_gnt",  p_bus.lsu_gnt, 0);
      tick();
      p_idle_inputs();
      p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'hDEAD_BEEF;
      settle();
      check("t1_if_rvalid", p_bus.if_rvalid, 1);
      check("t1_if_rdata",  p_bus.if_rdata, 32'hDEAD_BEEF);
      check("t1_lsu_rvld",  p_bus.lsu_rvalid, 0);
      check("t1_busy",      p_busy, 1);
      check("t1_wait_req",  p_bus.mem_req, 0);
      tick();
      p_idle_inputs();
      settle();
      check("t1_done_busy",  p_busy, 0);
      check("t1_done_rdata", p_bus.if_rdata, 0);

      // 2: conflict under LSU priority; fetch follows after LSU response.
      p_bus.if_req = 1; p_bus.if_addr = 32'h300;
      p_bus.lsu_req = 1; p_bus.lsu_we = 1; p_bus.lsu_be = 4'b0011;
      p_bus.lsu_addr = 32'h200; p_bus.lsu_wdata = 32'hCAFE_0001; p_bus.mem_gnt = 1;
      settle();
      check("t2_mem_we",    p_bus.mem_we, 1);
      check("t2_mem_be",    p_bus.mem_be, 4'b0011);
      check("t2_mem_addr",  p_bus.mem_addr, 32'h200);
      check("t2_mem_wdata", p_bus.mem_wdata, 32'hCAFE_0001);
      check("t2_lsu_gnt",   p_bus.lsu_gnt, 1);
      check("t2_if_gnt",    p_bus.if_gnt, 0);
      tick();
      p_bus.lsu_req = 0; p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'h11;
      settle();
      check("t2_lsu_rvalid", p_bus.lsu_rvalid, 1);
      check("t2_lsu_rdata",  p_bus.lsu_rdata, 32'h11);
      check("t2_wait_ifgnt", p_bus.if_gnt, 0);
      check("t2_wait_req",   p_bus.mem_req, 0);
      tick();
      p_bus.mem_rvalid = 0; p_bus.mem_rdata = '0;
      settle();
      check("t2_if_gnt2",  p_bus.if_gnt, 1);
      check("t2_if_addr2", p_bus.mem_addr, 32'h300);
      check("t2_if_we2",   p_bus.mem_we, 0);
      tick();
      p_idle_inputs();
      p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'h22;
      settle();
      check("t2_if_rvalid", p_bus.if_rvalid, 1);
      check("t2_if_rdata",  p_bus.if_rdata, 32'h22);
      tick();
      p_idle_inputs();

      // 4: grant held off 3 cycles; request changes/drops are ignored.
      p_bus.lsu_req = 1; p_bus.lsu_addr = 32'h400;
      settle();
      check("t4_c0_addr", p_bus.mem_addr, 32'h400);
      check("t4_c0_gnt",  p_bus.lsu_gnt, 0);
      tick();
      p_bus.lsu_req = 0; p_bus.lsu_addr = 32'h404;
      for (int c = 1; c < 3; c++) begin
         settle();
         check("t4_hold_req",  p_bus.mem_req, 1);
         check("t4_hold_addr", p_bus.mem_addr, 32'h400);
         check("t4_hold_gnt",  p_bus.lsu_gnt, 0);
         tick();
      end
      p_bus.mem_gnt = 1;
      settle();
      check("t4_c3_gnt",  p_bus.lsu_gnt, 1);
      check("t4_c3_addr", p_bus.mem_addr, 32'h400);
      tick();
      p_bus.mem_gnt = 0; p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'h1234_5678;
      settle();
      check("t4_rvalid", p_bus.lsu_rvalid, 1);
      check("t4_rdata",  p_bus.lsu_rdata, 32'h1234_5678);
      tick();
      p_idle_inputs();

      // 5: stray responses in IDLE, including the cycle after a real one.
      p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'hBAD;
      settle();
      check("t5_stray_if",   p_bus.if_rvalid, 0);
      check("t5_stray_lsu",  p_bus.lsu_rvalid, 0);
      check("t5_stray_busy", p_busy, 0);
      tick();
      p_idle_inputs();
      p_bus.if_req = 1; p_bus.if_addr = 32'h500; p_bus.mem_gnt = 1;
      tick();
      p_idle_inputs();
      p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'h77;
      settle();
      check("t5_real_rvalid", p_bus.if_rvalid, 1);
      tick();
      settle();
      check("t5_dup_rvalid", p_bus.if_rvalid, 0);
      check("t5_dup_rdata",  p_bus.if_rdata, 0);
      check("t5_dup_busy",   p_busy, 0);
      tick();
      p_idle_inputs();

      // 6: reset while waiting for a response; late response ignored.
      p_bus.if_req = 1; p_bus.if_addr = 32'h600; p_bus.mem_gnt = 1;
      tick();
      p_idle_inputs();
      settle();
      check("t6_busy_before", p_busy, 1);
      rst = 1;
      settle();
      p_outputs_zero("t6_rst");
      tick();
      rst = 0;
      p_bus.mem_rvalid = 1; p_bus.mem_rdata = 32'h66;
      settle();
      check("t6_late_rvalid", p_bus.if_rvalid, 0);
      check("t6_late_busy",   p_busy, 0);
      check("t6_late_req",    p_bus.mem_req, 0);
      tick();
      p_idle_inputs();

      // 3: round-robin with both requesters held high for 4 transactions.
      r_bus.if_req = 1; r_bus.if_addr = 32'h700;
      r_bus.lsu_req = 1; r_bus.lsu_addr = 32'h800;
      for (int t = 0; t < 4; t++) begin
         logic exp_if;
         exp_if = (t % 2) == 0;
         r_bus.mem_gnt = 1; r_bus.mem_rvalid = 0;
         settle();
         check("t3_if_gnt",  r_bus.if_gnt, exp_if);
         check("t3_lsu_gnt", r_bus.lsu_gnt, !exp_if);
         check("t3_addr",    r_bus.mem_addr, exp_if ? 32'h700 : 32'h800);
         tick();
         r_bus.mem_gnt = 0; r_bus.mem_rvalid = 1; r_bus.mem_rdata = 32'hA0 + t;
         settle();
         check("t3_if_rvalid",  r_bus.if_rvalid, exp_if);
         check("t3_lsu_rvalid", r_bus.lsu_rvalid, !exp_if);
         tick();
      end
      r_bus.if_req = 0; r_bus.lsu_req = 0; r_bus.mem_rvalid = 0;
      settle();
      check("t3_end_busy", r_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
